// File: rtl/fphub_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fphub_div_pkg
// Brief    : Shared types and helpers for the HUB floating-point SRT divider.
// Revision : 1.0
// ============================================================================
package fphub_div_pkg;

  localparam int FLAG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } flags_t;

  function automatic int bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // v holds {sign, exp, mant} zero-extended; exponent field sits at [m +: e]
  function automatic logic is_zero(input int e, input int m, input logic [63:0] v);
    return ((v >> m) & ((64'd1 << e) - 64'd1)) == 64'd0;
  endfunction

  function automatic logic is_inf(input int e, input int m, input logic [63:0] v);
    return ((v >> m) & ((64'd1 << e) - 64'd1)) == ((64'd1 << e) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fphub_srt_div_stream_step.sv
`default_nettype none
// ============================================================================
// Module   : srt_r2_step
// Brief    : Radix-2 SRT digit selection and residual update, purely combinational.
// Revision : 1.0
// ============================================================================
module srt_r2_step
  import fphub_div_pkg::*;
#(
  parameter int W = 28,
  parameter int F = 25
) (
  input  logic [W-1:0] w,
  input  logic [W-1:0] d,
  output logic         q_pos,
  output logic         q_neg,
  output logic [W-1:0] w_next
);

  localparam logic signed [W-1:0] c_HALF = {{(W-F){1'b0}}, 1'b1, {(F-1){1'b0}}};

  logic signed [W-1:0] w_2w;

  // |w| < d < 2 keeps 2w inside the two integer bits, so the dropped MSB is a copy of the sign
  assign w_2w  = $signed(w << 1);
  assign q_pos = (w_2w >= c_HALF);
  assign q_neg = (w_2w < -c_HALF);

  always_comb begin
    w_next = w_2w;
    if (q_pos) begin
      w_next = w_2w - d;
    end else if (q_neg) begin
      w_next = w_2w + d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fphub_srt_div_stream.sv
`default_nettype none
// ============================================================================
// Module   : fphub_srt_div_stream
// Brief    : Iterative radix-2 SRT HUB floating-point divider, valid/ready stream.
//            Define FPHUB_DIV_REMAINDER_EN to add the rem output port.
// Revision : 1.0
// ============================================================================
module fphub_srt_div_stream
  import fphub_div_pkg::*;
#(
  parameter int E  = 8,
  parameter int M  = 23,
  parameter int QB = M + 3
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [E+M:0]      x,
  input  logic [E+M:0]      d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [E+M:0]      res,
  output logic [FLAG_W-1:0] flags
`ifdef FPHUB_DIV_REMAINDER_EN
  ,
  output logic [E+M:0]      rem
`endif
);

  localparam int c_RW = M + 5;
  localparam int c_SF = M + 2;
  localparam int c_CW = $clog2(QB + 1);
  localparam int c_EW = E + 2;
  localparam logic [c_CW-1:0]        c_LAST  = c_CW'(QB - 1);
  localparam logic signed [c_EW-1:0] c_EBASE = c_EW'(bias(E) - 1);
  localparam logic signed [c_EW-1:0] c_EMAX  = c_EW'((1 << E) - 1);

  state_t                 r_state, w_state_nxt;
  logic [c_CW-1:0]        r_cnt;
  logic [c_RW-1:0]        r_w, r_d, w_w_next, w_w0, w_d_al;
  logic [QB-1:0]          r_p, r_n, w_q_raw, w_q_cor;
  logic                   w_q_pos, w_q_neg;
  logic                   r_sign, w_sign;
  logic signed [c_EW-1:0] r_er, w_er0, w_er;
  logic [E+M:0]           r_res, w_sp_res, w_norm_res;
  flags_t                 r_flags, w_sp_flags, w_norm_flags;
  logic                   w_xz, w_xi, w_dz, w_di, w_special, w_msb;
  logic [M-1:0]           w_mant;
  logic                   w_unused;

  assign w_sign    = x[E+M] ^ d[E+M];
  assign w_xz      = is_zero(E, M, 64'(x));
  assign w_xi      = is_inf(E, M, 64'(x));
  assign w_dz      = is_zero(E, M, 64'(d));
  assign w_di      = is_inf(E, M, 64'(d));
  assign w_special = w_xz | w_xi | w_dz | w_di;

  // Residual format: sign, 2 integer bits, M+2 fraction bits; w0 = Sx/2, divisor = Sd
  assign w_w0   = {3'b000, 1'b1, x[M-1:0], 1'b1};
  assign w_d_al = {2'b00, 1'b1, d[M-1:0], 1'b1, 1'b0};
  assign w_er0  = $signed({2'b00, x[E+M-1:M]}) - $signed({2'b00, d[E+M-1:M]}) + c_EBASE;

  srt_r2_step #(
    .W (c_RW),
    .F (c_SF)
  ) u_step (
    .w      (r_w),
    .d      (r_d),
    .q_pos  (w_q_pos),
    .q_neg  (w_q_neg),
    .w_next (w_w_next)
  );

  always_comb begin
    w_sp_flags = '0;
    w_sp_res   = {w_sign, {(E+M){1'b0}}};
    if ((w_xz && w_dz) || (w_xi && w_di)) begin
      w_sp_res           = {1'b0, {E{1'b1}}, {M{1'b0}}};
      w_sp_flags.invalid = 1'b1;
    end else if (w_xi) begin
      w_sp_res = {w_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (w_dz) begin
      w_sp_res               = {w_sign, {E{1'b1}}, {M{1'b0}}};
      w_sp_flags.div_by_zero = 1'b1;
    end
  end

  // Quotient carries one integer bit and M+2 fraction bits; exponent base is
  // ex-ed+BIAS-1 so a leading one in the integer position adds the missing 1
  always_comb begin
    w_q_raw      = r_p - r_n;
    w_q_cor      = w_q_raw - {{(QB-1){1'b0}}, r_w[c_RW-1]};
    w_msb        = w_q_cor[QB-1];
    w_mant       = w_msb ? w_q_cor[QB-2 -: M] : w_q_cor[QB-3 -: M];
    w_er         = r_er + $signed({{(c_EW-1){1'b0}}, w_msb});
    w_norm_flags = '0;
    w_norm_res   = {r_sign, w_er[E-1:0], w_mant};
    if (w_er >= c_EMAX) begin
      w_norm_res            = {r_sign, {E{1'b1}}, {M{1'b0}}};
      w_norm_flags.overflow = 1'b1;
    end else if (w_er[c_EW-1] || (w_er == '0)) begin
      w_norm_res             = {r_sign, {(E+M){1'b0}}};
      w_norm_flags.underflow = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_special ? DONE : ITER;
      ITER:    if (r_cnt == c_LAST) w_state_nxt = NORM;
      NORM:    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt   <= '0;
      r_w     <= '0;
      r_d     <= '0;
      r_p     <= '0;
      r_n     <= '0;
      r_sign  <= 1'b0;
      r_er    <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt  <= '0;
            r_w    <= w_w0;
            r_d    <= w_d_al;
            r_p    <= '0;
            r_n    <= '0;
            r_sign <= w_sign;
            r_er   <= w_er0;
            if (w_special) begin
              r_res   <= w_sp_res;
              r_flags <= w_sp_flags;
            end
          end
        end
        ITER: begin
          r_cnt <= r_cnt + c_CW'(1);
          r_w   <= w_w_next;
          r_p   <= {r_p[QB-2:0], w_q_pos};
          r_n   <= {r_n[QB-2:0], w_q_neg};
        end
        NORM: begin
          r_res   <= w_norm_res;
          r_flags <= w_norm_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign res       = r_res;
  assign flags     = r_flags;

`ifdef FPHUB_DIV_REMAINDER_EN
  localparam int c_LZW = $clog2(c_RW);
  localparam logic signed [c_EW-1:0] c_REM_OFF = c_EW'(1 - QB);

  logic [c_RW-1:0]        w_rem_fix, w_rem_norm;
  logic [c_LZW-1:0]       w_rem_lz;
  logic                   w_rem_nz, r_xs;
  logic signed [c_EW-1:0] w_rem_e;
  logic [E-1:0]           r_ed;
  logic [E+M:0]           w_rem_val, r_rem;

  always_comb begin
    w_rem_fix = r_w[c_RW-1] ? (r_w + r_d) : r_w;
    w_rem_lz  = '0;
    w_rem_nz  = 1'b0;
    for (int i = c_RW - 2; i >= 0; i--) begin
      if (!w_rem_nz && w_rem_fix[i]) begin
        w_rem_nz = 1'b1;
        w_rem_lz = c_LZW'(c_RW - 2 - i);
      end
    end
    w_rem_norm = w_rem_fix << w_rem_lz;
    w_rem_e    = $signed({2'b00, r_ed}) + c_REM_OFF
               - $signed({{(c_EW-c_LZW){1'b0}}, w_rem_lz});
    w_rem_val  = {r_xs, w_rem_e[E-1:0], w_rem_norm[c_RW-3 -: M]};
    if (!w_rem_nz || w_rem_e[c_EW-1] || (w_rem_e == '0)) begin
      w_rem_val = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rem <= '0;
      r_ed  <= '0;
      r_xs  <= 1'b0;
    end else if ((r_state == IDLE) && in_valid) begin
      r_rem <= '0;
      r_ed  <= d[E+M-1:M];
      r_xs  <= x[E+M];
    end else if (r_state == NORM) begin
      r_rem <= w_rem_val;
    end
  end

  assign rem      = r_rem;
  assign w_unused = ^{w_q_cor[0], w_rem_norm[c_RW-1:c_RW-2], w_rem_norm[2:0]};
`else
  assign w_unused = w_q_cor[0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fphub_srt_div_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fphub_srt_div_stream
// Brief    : Directed and model-based scoreboard bench for fphub_srt_div_stream.
// Revision : 1.0
// ============================================================================
module tb_fphub_srt_div_stream;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  flags;
`ifdef FPHUB_DIV_REMAINDER_EN
  logic [31:0] rem;
`endif

  int   total;
  int   bad;
  exp_t exp_q[$];

  fphub_srt_div_stream #(
    .E  (8),
    .M  (23),
    .QB (26)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
`ifdef FPHUB_DIV_REMAINDER_EN
    ,
    .rem       (rem)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: floor(Sx/Sd * 2^25) by integer division, then normalise
  function automatic exp_t model(input logic [31:0] xv, input logic [31:0] dv);
    exp_t        e;
    logic [63:0] sx, sd, q;
    int          er;
    logic        s;
    s  = xv[31] ^ dv[31];
    sx = {39'd0, 1'b1, xv[22:0], 1'b1};
    sd = {39'd0, 1'b1, dv[22:0], 1'b1};
    q  = (sx << 25) / sd;
    er = int'(xv[30:23]) - int'(dv[30:23]) + 127 - (q[25] ? 0 : 1);
    if (er >= 255) begin
      e.res   = {s, 8'hFF, 23'd0};
      e.flags = 4'b0010;
    end else if (er <= 0) begin
      e.res   = {s, 31'd0};
      e.flags = 4'b0001;
    end else begin
      e.res   = {s, er[7:0], (q[25] ? q[24:2] : q[23:1])};
      e.flags = 4'b0000;
    end
    e.lat = 28;
    return e;
  endfunction

  task automatic send(input logic [31:0] xv, input logic [31:0] dv, input logic [31:0] er,
                      input logic [3:0] ef, input int el);
    exp_t e;
    chk("in_ready", 32'(in_ready), 32'd1);
    x        = xv;
    d        = dv;
    in_valid = 1'b1;
    e.res    = er;
    e.flags  = ef;
    e.lat    = el;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] xv, input logic [31:0] dv);
    exp_t e;
    e = model(xv, dv);
    send(xv, dv, e.res, e.flags, e.lat);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic collect();
    exp_t e;
    int   n;
    wait_valid(n);
    chk("out_valid", 32'(out_valid), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("latency", 32'(n), 32'(e.lat));
      chk("res", res, e.res);
      chk("flags", 32'(flags), 32'(e.flags));
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rx, rd;
    exp_t        e;
    int          n;
    total     = 0;
    bad       = 0;
    rst_l     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    d         = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_l = 1'b1;
    @(negedge clk);

    send(32'h40C00000, 32'h40000000, 32'h403FFFFF, 4'b0000, 28); collect();
    send(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);  collect();
    send(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1);  collect();
    send(32'h00000000, 32'h00000000, 32'h7F800000, 4'b1000, 1);  collect();
    send(32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b1000, 1);  collect();
    send(32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 28); collect();
    send(32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 28); collect();
    send(32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000, 1);  collect();
    send(32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1);  collect();
    send(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);  collect();

    send_m(32'h3F800000, 32'h40400000); collect();
    send_m(32'h7F400000, 32'h3F800000); collect();
    send_m(32'h00800000, 32'h3F800000); collect();
    send_m(32'h00800000, 32'h3F800001); collect();
    for (int i = 0; i < 6; i++) begin
      rx        = $urandom;
      rd        = $urandom;
      rx[30:23] = 8'($urandom_range(60, 190));
      rd[30:23] = 8'($urandom_range(60, 190));
      send_m(rx, rd);
      collect();
    end

    // Backpressure: result held, new requests ignored while DONE waits
    out_ready = 1'b0;
    send_m(32'h40490FDB, 32'h402DF854);
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'd28);
    for (int i = 0; i < 10; i++) begin
      chk("bp_res", res, exp_q[0].res);
      chk("bp_flags", 32'(flags), 32'(exp_q[0].flags));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      x        = 32'h3F800000;
      d        = 32'h00000000;
      @(negedge clk);
    end
    e         = exp_q.pop_front();
    chk("bp_res_final", res, e.res);
    out_ready = 1'b1;
    x         = 32'hC1200000;
    d         = 32'h3E800000;
    @(negedge clk);
    chk("retire_out_valid", 32'(out_valid), 32'd0);
    chk("retire_in_ready", 32'(in_ready), 32'd1);
    send_m(32'hC1200000, 32'h3E800000); collect();

    // Asynchronous reset in the middle of an iteration
    send_m(32'h3FC00000, 32'h3F400000);
    repeat (9) @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_res", res, 32'd0);
    chk("arst_flags", 32'(flags), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    send_m(32'h40A00000, 32'h40400000); collect();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
